// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner.
package input_conditioner_pkg;

   localparam int GLITCH_COUNT_WIDTH = 8;

   typedef logic [GLITCH_COUNT_WIDTH-1:0] glitch_count_t;

   // Number of bits needed to hold values 0 .. value-1 (minimum 0 for value <= 1).
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioned input: synchronizer, debounce counter, edge pulses and a
// saturating count of rejected transitions.
module input_conditioner_channel
   import input_conditioner_pkg::*;
#(
   parameter int   SYNC_DEPTH             = 3,
   parameter int   DEBOUNCE_CLOCK_PERIODS = 20,
   parameter logic POLARITY               = 1'b1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          enable,
   input  logic          clear_counts,
   input  logic          in_raw,
   output logic          state,
   output logic          went_active,
   output logic          went_inactive,
   output logic          changed,
   output glitch_count_t glitch_count
);

   localparam int             CNT_W    = clog2(DEBOUNCE_CLOCK_PERIODS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLOCK_PERIODS - 1);
   localparam logic           IDLE_RAW = ~POLARITY;

   (* async_reg = "true" *) logic sync_first;
   logic [SYNC_DEPTH-2:0] sync_rest;
   logic [CNT_W-1:0]      cnt;
   logic                  sample;
   logic                  glitch;

   // Synchronizer chain; resets to the inactive raw level so release is quiet.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_first <= IDLE_RAW;
         sync_rest  <= {(SYNC_DEPTH-1){IDLE_RAW}};
      end else begin
         sync_first   <= in_raw;
         sync_rest[0] <= sync_first;
         for (int k = 1; k < SYNC_DEPTH - 1; k++) begin
            sync_rest[k] <= sync_rest[k-1];
         end
      end
   end

   assign sample = sync_rest[SYNC_DEPTH-2] ~^ POLARITY;
   assign glitch = enable && (sample == state) && (cnt != '0);

   // Debounce: accept a change only after DEBOUNCE_CLOCK_PERIODS differing samples.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= 1'b0;
         cnt           <= '0;
         went_active   <= 1'b0;
         went_inactive <= 1'b0;
         changed       <= 1'b0;
      end else begin
         went_active   <= 1'b0;
         went_inactive <= 1'b0;
         changed       <= 1'b0;
         if (!enable) begin
            cnt <= '0;
         end else if (sample == state) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            state         <= sample;
            cnt           <= '0;
            went_active   <= sample;
            went_inactive <= ~sample;
            changed       <= 1'b1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Rejected-transition counter; clear takes priority over a coincident glitch.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         glitch_count <= '0;
      end else if (clear_counts) begin
         glitch_count <= '0;
      end else if (glitch && (glitch_count != '1)) begin
         glitch_count <= glitch_count + GLITCH_COUNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: independent synchronize + debounce per bit.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int               WIDTH                  = 4,
   parameter int               SYNC_DEPTH             = 3,
   parameter int               DEBOUNCE_CLOCK_PERIODS = 20,
   parameter logic [WIDTH-1:0] POLARITY               = {WIDTH{1'b1}}
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                enable,
   input  logic                                clear_counts,
   input  logic [WIDTH-1:0]                    in_raw,
   output logic [WIDTH-1:0]                    state,
   output logic [WIDTH-1:0]                    went_active,
   output logic [WIDTH-1:0]                    went_inactive,
   output logic [WIDTH-1:0]                    changed,
   output logic [GLITCH_COUNT_WIDTH*WIDTH-1:0] glitch_count
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      input_conditioner_channel #(
         .SYNC_DEPTH             (SYNC_DEPTH),
         .DEBOUNCE_CLOCK_PERIODS (DEBOUNCE_CLOCK_PERIODS),
         .POLARITY               (POLARITY[i])
      ) u_chan (
         .clock         (clock),
         .reset_n       (reset_n),
         .enable        (enable),
         .clear_counts  (clear_counts),
         .in_raw        (in_raw[i]),
         .state         (state[i]),
         .went_active   (went_active[i]),
         .went_inactive (went_inactive[i]),
         .changed       (changed[i]),
         .glitch_count  (glitch_count[GLITCH_COUNT_WIDTH*i +: GLITCH_COUNT_WIDTH])
      );
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (WIDTH=4, SYNC_DEPTH=3, DEBOUNCE=10, POLARITY=0111).
module tb_input_conditioner;

   logic        clock;
   logic        reset_n;
   logic        enable;
   logic        clear_counts;
   logic [3:0]  in_raw;
   logic [3:0]  state;
   logic [3:0]  went_active;
   logic [3:0]  went_inactive;
   logic [3:0]  changed;
   logic [31:0] glitch_count;

   int n_vec;
   int n_err;
   int act_cnt [4];
   int inact_cnt [4];
   int chg_cnt [4];
   int act_base [4];

   input_conditioner #(
      .WIDTH                  (4),
      .SYNC_DEPTH             (3),
      .DEBOUNCE_CLOCK_PERIODS (10),
      .POLARITY               (4'b0111)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .enable        (enable),
      .clear_counts  (clear_counts),
      .in_raw        (in_raw),
      .state         (state),
      .went_active   (went_active),
      .went_inactive (went_inactive),
      .changed       (changed),
      .glitch_count  (glitch_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         act_cnt[i]   = 0;
         inact_cnt[i] = 0;
         chg_cnt[i]   = 0;
      end
   end

   // Pulse tally, sampled away from the active edge.
   always @(negedge clock) begin
      for (int i = 0; i < 4; i++) begin
         act_cnt[i]   = act_cnt[i] + int'(went_active[i]);
         inact_cnt[i] = inact_cnt[i] + int'(went_inactive[i]);
         chg_cnt[i]   = chg_cnt[i] + int'(changed[i]);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic snap();
      for (int i = 0; i < 4; i++) act_base[i] = act_cnt[i];
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      reset_n      = 1'b0;
      enable       = 1'b1;
      clear_counts = 1'b0;
      in_raw       = 4'b1000;

      // Reset and quiet idle
      tick(3);
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_glitch", glitch_count, 32'h0);
      reset_n = 1'b1;
      tick(50);
      chk("idle_state", 32'(state), 32'h0);
      chk("idle_glitch", glitch_count, 32'h0);
      chk("idle_pulses", 32'(act_cnt[0] + act_cnt[1] + act_cnt[2] + act_cnt[3]
                         + inact_cnt[0] + inact_cnt[1] + inact_cnt[2] + inact_cnt[3]
                         + chg_cnt[0] + chg_cnt[1] + chg_cnt[2] + chg_cnt[3]), 32'h0);

      // Ch0 clean rise: pulse exactly on edge 13
      snap();
      in_raw[0] = 1'b1;
      tick(12);
      chk("c0_e12_state", 32'(state[0]), 32'h0);
      chk("c0_e12_act", 32'(went_active[0]), 32'h0);
      tick(1);
      chk("c0_e13_act", 32'(went_active[0]), 32'h1);
      chk("c0_e13_chg", 32'(changed[0]), 32'h1);
      chk("c0_e13_inact", 32'(went_inactive[0]), 32'h0);
      chk("c0_e13_state", 32'(state[0]), 32'h1);
      tick(1);
      chk("c0_e14_act", 32'(went_active[0]), 32'h0);
      chk("c0_e14_chg", 32'(changed[0]), 32'h0);
      tick(16);
      chk("c0_act_total", 32'(act_cnt[0] - act_base[0]), 32'h1);
      chk("c0_glitch", 32'(glitch_count[7:0]), 32'h0);

      // Ch1 short pulse rejected
      snap();
      in_raw[1] = 1'b1;
      tick(5);
      in_raw[1] = 1'b0;
      tick(20);
      chk("c1_state", 32'(state[1]), 32'h0);
      chk("c1_act_total", 32'(act_cnt[1] - act_base[1]), 32'h0);
      chk("c1_glitch", 32'(glitch_count[15:8]), 32'h1);

      // Ch2 bouncing then settles high
      snap();
      for (int r = 0; r < 2; r++) begin
         in_raw[2] = 1'b1;
         tick(3);
         in_raw[2] = 1'b0;
         tick(3);
      end
      in_raw[2] = 1'b1;
      tick(30);
      chk("c2_act_total", 32'(act_cnt[2] - act_base[2]), 32'h1);
      chk("c2_state", 32'(state[2]), 32'h1);
      chk("c2_glitch", 32'(glitch_count[23:16]), 32'h2);

      // Ch3 (active-low) glitch saturation
      snap();
      for (int r = 0; r < 300; r++) begin
         in_raw[3] = 1'b0;
         tick(5);
         in_raw[3] = 1'b1;
         tick(5);
      end
      chk("c3_glitch_sat", 32'(glitch_count[31:24]), 32'hFF);
      chk("c3_state", 32'(state[3]), 32'h0);
      chk("c3_act_total", 32'(act_cnt[3] - act_base[3]), 32'h0);

      // Clear coincident with a glitch edge (edge 9 after the low pulse starts)
      in_raw[3] = 1'b0;
      tick(5);
      in_raw[3] = 1'b1;
      tick(3);
      clear_counts = 1'b1;
      tick(1);
      clear_counts = 1'b0;
      chk("clr_all", glitch_count, 32'h0);
      tick(5);
      in_raw[3] = 1'b0;
      tick(5);
      in_raw[3] = 1'b1;
      tick(10);
      chk("c3_after_clr", 32'(glitch_count[31:24]), 32'h1);

      // Async reset mid-debounce on ch1 (counter at 5)
      in_raw[1] = 1'b1;
      tick(8);
      chk("pre_rst_state", 32'(state), 32'h5);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_state", 32'(state), 32'h0);
      chk("async_glitch", glitch_count, 32'h0);
      chk("async_pulses", 32'({went_active, went_inactive, changed}), 32'h0);
      in_raw = 4'b1000;
      tick(3);
      reset_n = 1'b1;
      snap();
      tick(20);
      chk("post_rst_state", 32'(state), 32'h0);
      chk("post_rst_act", 32'(act_cnt[0] + act_cnt[1] + act_cnt[2] + act_cnt[3]
                              - act_base[0] - act_base[1] - act_base[2] - act_base[3]), 32'h0);

      // Enable low during a held change, then full wait after enable returns
      snap();
      enable    = 1'b0;
      in_raw[0] = 1'b1;
      tick(30);
      chk("dis_state", 32'(state[0]), 32'h0);
      chk("dis_act", 32'(act_cnt[0] - act_base[0]), 32'h0);
      enable = 1'b1;
      tick(9);
      chk("en_e9_state", 32'(state[0]), 32'h0);
      tick(1);
      chk("en_e10_state", 32'(state[0]), 32'h1);
      chk("en_e10_act", 32'(went_active[0]), 32'h1);
      tick(5);

      // Simultaneous events across channels, including a falling change
      in_raw = 4'b1110;
      tick(12);
      chk("sim_e12_chg", 32'(changed), 32'h0);
      tick(1);
      chk("sim_act", 32'(went_active), 32'h6);
      chk("sim_inact", 32'(went_inactive), 32'h1);
      chk("sim_chg", 32'(changed), 32'h7);
      chk("sim_state", 32'(state), 32'h6);
      tick(1);
      chk("sim_after", 32'(changed), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
